// File: rtl/keypress_pkg.sv
// Shared definitions for the keypress command block: FSM state encoding
// and the default debounce length.
package keypress_pkg;

    // Default number of stable synchronized samples needed to accept a press/release
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/keypress_cmd_if.sv
// Bundle of raw pushbutton/switch levels and the registered command outputs.
interface keypress_cmd_if;
    logic       btn;
    logic       sw_check;
    logic       sw_mode;
    logic       sw_direction;
    logic [3:0] sw_value;
    logic       enable;
    logic       check;
    logic       mode;
    logic       direction;
    logic [3:0] value;

    // Side that drives the raw inputs and consumes the command
    modport master (
        output btn, sw_check, sw_mode, sw_direction, sw_value,
        input  enable, check, mode, direction, value
    );

    // Side implemented by keypress_cmd
    modport slave (
        input  btn, sw_check, sw_mode, sw_direction, sw_value,
        output enable, check, mode, direction, value
    );
endinterface

// File: rtl/keypress_cmd_sync2.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] q_r;

    // Two back-to-back flops to settle asynchronous levels into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            q_r    <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/keypress_cmd.sv
// Debounces a pushbutton and, on each accepted press, issues a one-cycle
// enable together with a snapshot of the slide switches.
module keypress_cmd
    import keypress_pkg::*;
#(
    // Legal range 2..65535
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    keypress_cmd_if.slave bus
);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [7:0]  raw_s;
    logic [7:0]  sync_s;
    logic        btn_s;
    logic        sw_check_s;
    logic        sw_mode_s;
    logic        sw_direction_s;
    logic [3:0]  sw_value_s;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic        accept_s;

    logic        enable_r;
    logic        check_r;
    logic        mode_r;
    logic        direction_r;
    logic [3:0]  value_r;

    assign raw_s = {bus.btn, bus.sw_check, bus.sw_mode, bus.sw_direction, bus.sw_value};

    sync2 #(.WIDTH(8)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw_s),
        .q     (sync_s)
    );

    assign btn_s          = sync_s[7];
    assign sw_check_s     = sync_s[6];
    assign sw_mode_s      = sync_s[5];
    assign sw_direction_s = sync_s[4];
    assign sw_value_s     = sync_s[3:0];

    // Next-state, debounce counter and press-accept decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_s) begin
                    state_next_s = PRESS_WAIT;
                    cnt_next_s   = 16'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = PRESSED;
                    accept_s     = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + 16'd1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next_s = RELEASE_WAIT;
                    cnt_next_s   = 16'd0;
                end else begin
                    state_next_s = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: back to held, no new command
                    state_next_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s   = cnt_r + 16'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 16'd0;
            end
        endcase
    end

    // State and debounce counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Command pulse and switch snapshot, loaded together on an accepted press
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_r    <= 1'b0;
            check_r     <= 1'b0;
            mode_r      <= 1'b0;
            direction_r <= 1'b0;
            value_r     <= 4'h0;
        end else begin
            enable_r <= accept_s;
            if (accept_s) begin
                check_r     <= sw_check_s;
                mode_r      <= sw_mode_s;
                direction_r <= sw_direction_s;
                value_r     <= sw_value_s;
            end
        end
    end

    assign bus.enable    = enable_r;
    assign bus.check     = check_r;
    assign bus.mode      = mode_r;
    assign bus.direction = direction_r;
    assign bus.value     = value_r;
endmodule

// File: tb/tb_keypress_cmd.sv
// Directed bench for keypress_cmd with DEBOUNCE_CYCLES=4; expected commands
// are queued at stimulus time and matched whenever enable is seen.
module tb_keypress_cmd;
    import keypress_pkg::*;

    typedef struct {
        int         cycle;
        logic       check;
        logic       mode;
        logic       direction;
        logic [3:0] value;
    } exp_t;

    logic clock;
    logic reset;
    int   edge_cnt;
    int   total;
    int   bad;
    exp_t sb[$];

    keypress_cmd_if bus ();

    keypress_cmd #(.DEBOUNCE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expect a command 7 edges after the current sample point, with current switches
    task automatic push_exp();
        exp_t e;
        e.cycle     = edge_cnt + 7;
        e.check     = bus.sw_check;
        e.mode      = bus.sw_mode;
        e.direction = bus.sw_direction;
        e.value     = bus.sw_value;
        sb.push_back(e);
    endtask

    task automatic push_press();
        push_exp();
        bus.btn = 1'b1;
    endtask

    // Scoreboard: every enable must match the oldest queued expectation
    always @(negedge clock) begin
        if (bus.enable === 1'b1) begin
            chk("enable_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("enable_cycle", 32'(edge_cnt), 32'(e.cycle));
                chk("snap_check", 32'(bus.check), 32'(e.check));
                chk("snap_mode", 32'(bus.mode), 32'(e.mode));
                chk("snap_direction", 32'(bus.direction), 32'(e.direction));
                chk("snap_value", 32'(bus.value), 32'(e.value));
            end
        end
    end

    initial begin
        int c;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.btn = 1'b0;
        bus.sw_check = 1'b0;
        bus.sw_mode = 1'b0;
        bus.sw_direction = 1'b0;
        bus.sw_value = 4'h0;

        // Reset state
        step(3);
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_check", 32'(bus.check), 32'd0);
        chk("rst_mode", 32'(bus.mode), 32'd0);
        chk("rst_direction", 32'(bus.direction), 32'd0);
        chk("rst_value", 32'(bus.value), 32'h0);
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        reset = 1'b0;
        step(2);

        // Clean press
        bus.sw_value = 4'h9;
        bus.sw_mode  = 1'b1;
        step(3);
        push_press();
        step(20);
        bus.btn = 1'b0;
        step(8);
        chk("clean_idle", 32'(dut.state_r), 32'(IDLE));
        chk("clean_hold_value", 32'(bus.value), 32'h9);
        chk("clean_hold_mode", 32'(bus.mode), 32'd1);

        // Press bounce: 2 high, 1 low, then held
        bus.sw_check = 1'b1;
        bus.sw_direction = 1'b1;
        bus.sw_mode = 1'b0;
        bus.sw_value = 4'h5;
        step(3);
        bus.btn = 1'b1;
        step(2);
        bus.btn = 1'b0;
        step(1);
        push_press();
        step(15);
        bus.btn = 1'b0;
        step(8);

        // Short glitch with switch changes: no command, outputs unchanged
        bus.sw_value = 4'hF;
        bus.sw_check = 1'b0;
        step(3);
        bus.btn = 1'b1;
        step(3);
        bus.btn = 1'b0;
        step(8);
        chk("glitch_idle", 32'(dut.state_r), 32'(IDLE));
        chk("glitch_value", 32'(bus.value), 32'h5);
        chk("glitch_check", 32'(bus.check), 32'd1);
        chk("glitch_mode", 32'(bus.mode), 32'd0);
        chk("glitch_direction", 32'(bus.direction), 32'd1);

        // Release bounce: low 2, high 1, low held
        push_press();
        step(12);
        bus.btn = 1'b0;
        step(2);
        bus.btn = 1'b1;
        step(1);
        bus.btn = 1'b0;
        step(6);
        chk("relb_wait", 32'(dut.state_r), 32'(RELEASE_WAIT));
        step(1);
        chk("relb_idle", 32'(dut.state_r), 32'(IDLE));
        step(4);

        // Reset in the middle of debouncing a held press
        bus.sw_value = 4'hA;
        bus.sw_mode  = 1'b1;
        bus.sw_check = 1'b1;
        step(3);
        c = edge_cnt;
        bus.btn = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rmid_edge", 32'(edge_cnt), 32'(c + 4));
        chk("rmid_enable", 32'(bus.enable), 32'd0);
        chk("rmid_value", 32'(bus.value), 32'h0);
        chk("rmid_mode", 32'(bus.mode), 32'd0);
        chk("rmid_state", 32'(dut.state_r), 32'(IDLE));
        push_exp();
        step(6);
        chk("rmid_pre_enable", 32'(bus.enable), 32'd0);
        chk("rmid_pre_value", 32'(bus.value), 32'h0);
        step(10);
        bus.btn = 1'b0;
        step(8);

        // Switch change while held keeps the old snapshot
        bus.sw_value = 4'h3;
        step(3);
        push_press();
        step(10);
        bus.sw_value = 4'hC;
        step(5);
        chk("swchg_held", 32'(bus.value), 32'h3);
        bus.btn = 1'b0;
        step(8);
        chk("swchg_released", 32'(bus.value), 32'h3);
        push_press();
        step(10);
        bus.btn = 1'b0;
        step(8);
        chk("swchg_new", 32'(bus.value), 32'hC);

        step(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
